// File: rtl/parity_frame_tx.sv
// Serial transmitter for a 4-bit nibble with even parity.
// Frame on TXD: start(0), A, B, C, D, parity, stop(1); each bit lasts BIT_TICKS cycles.
module parity_frame_tx #(
  parameter int BIT_TICKS = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic LOAD,
  output logic READY,
  output logic TXD,
  output logic EP,
  output logic DONE
);

  localparam int              CW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0]   LAST_TICK = CW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_tick;
  logic [1:0]    r_bit_idx;
  logic [3:0]    r_shift;
  logic          r_ep;
  logic          w_tick_last;
  logic          w_accept;

  assign w_tick_last = (r_tick == LAST_TICK);
  assign EP          = r_ep;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    READY        = 1'b0;
    TXD          = 1'b1;
    DONE         = 1'b0;
    case (r_state)
      IDLE: begin
        READY = 1'b1;
        if (LOAD) begin
          w_accept     = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        TXD = 1'b0;
        if (w_tick_last) w_next_state = DATA;
      end
      DATA: begin
        TXD = r_shift[0];
        if (w_tick_last && (r_bit_idx == 2'd3)) w_next_state = PARITY;
      end
      PARITY: begin
        TXD = r_ep;
        if (w_tick_last) w_next_state = STOP;
      end
      STOP: begin
        if (w_tick_last) begin
          DONE         = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Tick counter restarts at every bit boundary and stays cleared while idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick <= '0;
    end else if ((r_state == IDLE) || w_tick_last) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + CW'(1);
    end
  end

  // A sits in bit 0 so the data bits leave LSB first; parity is frozen until the next accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_ep      <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= {D, C, B, A};
      r_bit_idx <= '0;
      r_ep      <= A ^ B ^ C ^ D;
    end else if ((r_state == DATA) && w_tick_last) begin
      r_shift   <= {1'b0, r_shift[3:1]};
      r_bit_idx <= r_bit_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: one instance at BIT_TICKS=4, one at BIT_TICKS=1,
// compared cycle by cycle against a frame model built from the nibble.
module tb_parity_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a, b, c, d, load4, load1;
  logic ready4, txd4, ep4, done4;
  logic ready1, txd1, ep1, done1;

  int vectors     = 0;
  int miscompares = 0;

  logic cap_txd[64], cap_ready[64], cap_done[64], cap_ep[64];

  parity_frame_tx #(.BIT_TICKS(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .C(c), .D(d), .LOAD(load4),
    .READY(ready4), .TXD(txd4), .EP(ep4), .DONE(done4)
  );

  parity_frame_tx #(.BIT_TICKS(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .C(c), .D(d), .LOAD(load1),
    .READY(ready1), .TXD(txd1), .EP(ep1), .DONE(done1)
  );

  // Frame bit i as it should appear on the line; abcd[3] is A.
  function automatic logic [6:0] frame_bits(input logic [3:0] abcd);
    logic [6:0] f;
    f[0] = 1'b0;
    f[1] = abcd[3];
    f[2] = abcd[2];
    f[3] = abcd[1];
    f[4] = abcd[0];
    f[5] = abcd[3] ^ abcd[2] ^ abcd[1] ^ abcd[0];
    f[6] = 1'b1;
    return f;
  endfunction

  // Expected {TXD, READY, DONE} in cycle k (1 = first cycle after accept) of a
  // stream of frames separated by one idle cycle.
  function automatic logic [2:0] model_line(input logic [3:0] abcd, input int bt, input int k);
    int         p;
    logic [6:0] f;
    p = (k - 1) % (7 * bt + 1);
    f = frame_bits(abcd);
    if (p == 7 * bt) return 3'b110;
    return {f[p / bt], 1'b0, (p == 7 * bt - 1)};
  endfunction

  function automatic logic parity(input logic [3:0] abcd);
    return abcd[3] ^ abcd[2] ^ abcd[1] ^ abcd[0];
  endfunction

  task automatic wait_idle(input bit sel1);
    int i;
    i = 0;
    while (((sel1 ? ready1 : ready4) !== 1'b1) && (i < 100)) begin
      @(posedge clk); #1;
      i++;
    end
    if (i == 100) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: READY stuck at %b, required 1", sel1 ? ready1 : ready4);
    end
  endtask

  // Presents a nibble with LOAD, then records outputs for n cycles after the accept edge.
  // At dist_cycle the nibble is replaced and LOAD pulsed again for one cycle.
  task automatic capture(input logic [3:0] abcd, input bit sel1, input bit hold,
                         input int n, input int dist_cycle, input logic [3:0] dist_abcd);
    wait_idle(sel1);
    @(negedge clk);
    {a, b, c, d} = abcd;
    if (sel1) load1 = 1'b1; else load4 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      cap_txd[k]   = sel1 ? txd1   : txd4;
      cap_ready[k] = sel1 ? ready1 : ready4;
      cap_done[k]  = sel1 ? done1  : done4;
      cap_ep[k]    = sel1 ? ep1    : ep4;
      if (k == dist_cycle) begin
        {a, b, c, d} = dist_abcd;
        if (sel1) load1 = 1'b1; else load4 = 1'b1;
      end else if (!hold) begin
        load1 = 1'b0;
        load4 = 1'b0;
      end
      if (k < n) begin
        @(posedge clk); #1;
      end
    end
    load1 = 1'b0;
    load4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load4 = 1'b0;
    load1 = 1'b0;
    {a, b, c, d} = 4'b1111;
    #2;
    vectors++;
    if ({txd4, ready4, ep4, done4, txd1, ready1, ep1, done1} !== 8'b1100_1100) begin
      miscompares++;
      $display("FAIL reset_async: got %b, required 11001100",
               {txd4, ready4, ep4, done4, txd1, ready1, ep1, done1});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if ({txd4, ready4, ep4, done4, txd1, ready1, ep1, done1} !== 8'b1100_1100) begin
      miscompares++;
      $display("FAIL reset_held: got %b, required 11001100",
               {txd4, ready4, ep4, done4, txd1, ready1, ep1, done1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame_contents();
    logic [3:0] list[7];
    list[0] = 4'b1011;
    list[1] = 4'b0000;
    list[2] = 4'b1111;
    for (int i = 3; i < 7; i++) list[i] = 4'($urandom_range(15));
    foreach (list[i]) begin
      capture(list[i], 1'b0, 1'b0, 29, 0, 4'b0000);
      for (int k = 1; k <= 29; k++) begin
        vectors++;
        if ({cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]} !==
            {model_line(list[i], 4, k), parity(list[i])}) begin
          miscompares++;
          $display("FAIL frame4 abcd=%b cycle %0d: txd/ready/done/ep=%b required %b", list[i], k,
                   {cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]},
                   {model_line(list[i], 4, k), parity(list[i])});
        end
      end
    end
  endtask

  task automatic test_bit_ticks_1();
    logic [3:0] list[5];
    list[0] = 4'b0100;
    for (int i = 1; i < 5; i++) list[i] = 4'($urandom_range(15));
    foreach (list[i]) begin
      capture(list[i], 1'b1, 1'b0, 8, 0, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
        vectors++;
        if ({cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]} !==
            {model_line(list[i], 1, k), parity(list[i])}) begin
          miscompares++;
          $display("FAIL frame1 abcd=%b cycle %0d: txd/ready/done/ep=%b required %b", list[i], k,
                   {cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]},
                   {model_line(list[i], 1, k), parity(list[i])});
        end
      end
    end
  endtask

  task automatic test_ignore_load();
    capture(4'b0110, 1'b0, 1'b0, 29, 10, 4'b1001);
    for (int k = 1; k <= 29; k++) begin
      vectors++;
      if ({cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]} !==
          {model_line(4'b0110, 4, k), 1'b0}) begin
        miscompares++;
        $display("FAIL ignore_load cycle %0d: txd/ready/done/ep=%b required %b", k,
                 {cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]},
                 {model_line(4'b0110, 4, k), 1'b0});
      end
    end
  endtask

  task automatic test_reset_abort();
    capture(4'b1101, 1'b0, 1'b0, 12, 0, 4'b0000);
    vectors++;
    if ({cap_txd[12], cap_ready[12], cap_done[12]} !== model_line(4'b1101, 4, 12)) begin
      miscompares++;
      $display("FAIL abort_midframe: txd/ready/done=%b required %b",
               {cap_txd[12], cap_ready[12], cap_done[12]}, model_line(4'b1101, 4, 12));
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({txd4, ready4, ep4, done4} !== 4'b1100) begin
      miscompares++;
      $display("FAIL abort_async: txd/ready/ep/done=%b required 1100", {txd4, ready4, ep4, done4});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({txd4, ready4, done4} !== 3'b110) begin
        miscompares++;
        $display("FAIL abort_held cycle %0d: txd/ready/done=%b required 110", i, {txd4, ready4, done4});
      end
    end
    rst_n = 1'b1;
    capture(4'b0011, 1'b0, 1'b0, 29, 0, 4'b0000);
    for (int k = 1; k <= 29; k++) begin
      vectors++;
      if ({cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]} !==
          {model_line(4'b0011, 4, k), 1'b0}) begin
        miscompares++;
        $display("FAIL after_reset cycle %0d: txd/ready/done/ep=%b required %b", k,
                 {cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]},
                 {model_line(4'b0011, 4, k), 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    capture(4'b1000, 1'b0, 1'b1, 58, 0, 4'b0000);
    for (int k = 1; k <= 58; k++) begin
      vectors++;
      if ({cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]} !==
          {model_line(4'b1000, 4, k), 1'b1}) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: txd/ready/done/ep=%b required %b", k,
                 {cap_txd[k], cap_ready[k], cap_done[k], cap_ep[k]},
                 {model_line(4'b1000, 4, k), 1'b1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_contents();
    test_bit_ticks_1();
    test_ignore_load();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 SHALL have parameter: BIT_TICKS, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 SHALL have port: CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: A, B, C, D  input  1 each  data nibble; A is transmitted first, D last.
REQ-005 SHALL have port: LOAD  input  1  request to send the nibble on A..D.
REQ-006 SHALL have port: READY  output  1  high when a LOAD will be accepted.
REQ-007 SHALL have port: TXD  output  1  serial line, idle high.
REQ-008 SHALL have port: EP  output  1  even-parity bit of the frame most recently accepted (A^B^C^D).
REQ-009 SHALL have port: DONE  output  1  one-cycle pulse at end of stop bit.

Function
REQ-010 SHALL transmit a 7-bit frame: start(0), A, B, C, D, EP, stop(1).
REQ-011 SHALL hold every frame bit on TXD for exactly BIT_TICKS cycles; frame length 7*BIT_TICKS cycles.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; DATA uses a 2-bit bit index 0..3.
REQ-013 SHALL accept a frame on a rising edge where state=IDLE and LOAD=1 (handshake: LOAD & READY).
REQ-014 SHALL on accept register A..D into a shift register and register EP=A^B^C^D; inputs ignored afterwards until next accept.
REQ-015 SHALL drive TXD=0 (START) in the first cycle after accept; latency accept-edge to start bit = 0 cycles after the edge.
REQ-016 SHALL assert READY combinationally from state: READY=1 only in IDLE.
REQ-017 SHALL ignore LOAD while not IDLE; no queuing, no error flag.
REQ-018 SHALL advance IDLE->START->DATA(x4 bits)->PARITY->STOP->IDLE, each transition when the tick counter reaches BIT_TICKS-1.
REQ-019 SHALL reset the tick counter to 0 at each bit boundary; counter width sized for BIT_TICKS-1, no wrap within a bit.
REQ-020 SHALL pulse DONE high for exactly one cycle, in the last cycle of the stop bit.
REQ-021 SHALL allow back-to-back frames: if LOAD=1 in the first IDLE cycle after STOP, next start bit follows with no extra idle cycles beyond that one.
REQ-022 SHALL work with BIT_TICKS=1 (one cycle per bit, 7-cycle frame).
REQ-023 SHALL hold EP stable from accept until the next accept.

Reset
REQ-024 SHALL on RST_N=0, immediately and regardless of CLK: state=IDLE, TXD=1, READY=1, EP=0, DONE=0, counters and shift register 0.
REQ-025 SHALL abort any frame in progress on reset; no DONE pulse for an aborted frame.
REQ-026 SHALL accept a LOAD on the first rising edge after RST_N deasserts.

Verification
REQ-027 SHALL verify: BIT_TICKS=4, ABCD=1011, LOAD pulse -> EP=1; TXD = 0,1,0,1,1,1,1 each for 4 cycles; DONE in cycle 28; READY=1 in cycle 29.
REQ-028 SHALL verify: ABCD=0000 -> EP=0; TXD = 0,0,0,0,0,0,1; ABCD=1111 -> EP=0.
REQ-029 SHALL verify: LOAD with ABCD=0110 asserted again at cycle 10 of a frame, ABCD changed to 1001 -> ignored; frame carries 0110, EP=0.
REQ-030 SHALL verify: RST_N low at cycle 12 of a frame -> TXD=1, READY=1 asynchronously, no DONE; new LOAD after release sends a complete frame.
REQ-031 SHALL verify: LOAD held high continuously, ABCD=1000 -> consecutive frames, EP=1, exactly one idle cycle (TXD=1, READY=1) between frames.
REQ-032 SHALL verify: BIT_TICKS=1, ABCD=0100 -> TXD = 0,0,1,0,0,1,1 on 7 consecutive cycles, DONE in cycle 7.
